mac_operand_loader: RTL and testbench

- Bit-serial front end for the 32-lane binary MAC array.
- Shifts input and weight vectors in one bit per clock from two pin-limited serial lines, then presents them as packed parallel operands to the MAC.
- Waits out the MAC's one-cycle register latency, captures the MAC sum and returns it with a one-cycle valid pulse.
- Optionally retains the previous weight vector so only inputs are reloaded (weight-stationary reuse).

---
 rtl/mac_pkg.sv | 22 ++
 rtl/serial_shift_lane.sv | 42 ++++
 rtl/mac_operand_loader.sv | 118 +++++++++++
 tb/tb_mac_operand_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and loader state type for the bit-serial MAC front end.
// The MAC array imports the same constants so both sides agree on widths.
package mac_pkg;

    localparam int NUM_MAC     = 32;
    localparam int BITS_IN     = 1;
    localparam int BITS_WEIGHT = 1;
    localparam int OUT_W       = BITS_IN + BITS_WEIGHT + $clog2(NUM_MAC) - 1;

    localparam int IN_W  = NUM_MAC * BITS_IN;
    localparam int WT_W  = NUM_MAC * BITS_WEIGHT;
    localparam int L_MAX = (IN_W > WT_W) ? IN_W : WT_W;
    localparam int CNT_W = $clog2(L_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        CAPT = 2'd3
    } loader_state_e;

endpackage

// File: rtl/serial_shift_lane.sv
// One serial-to-parallel lane: shifts right with the new bit entering at the MSB,
// so the first bit received ends up at bit 0. Freezes once WIDTH bits are in.
module serial_shift_lane #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             first,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] par_next
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH:0]   cat;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             shifting;

    assign cat      = {bit_in, sr};
    assign shifted  = cat[WIDTH:1];
    assign full     = (cnt == CW'(WIDTH));
    // A new load restarts the fill count even if the lane was left full.
    assign shifting = en && (first || !full);
    // Contents as they will be after this edge, so the owner can copy a
    // completed vector on the same edge that takes the last bit.
    assign par_next = shifting ? shifted : sr;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shifting) begin
            sr  <= shifted;
            cnt <= first ? CW'(1) : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mac_operand_loader.sv
// Bit-serial loader for the binary MAC array: collects input/weight vectors, presents
// them packed, waits out the MAC register stage and returns the sum with a valid pulse.
module mac_operand_loader
    import mac_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             keep_weight,
    input  logic             ser_in,
    input  logic             ser_w,
    output logic [IN_W-1:0]  in_packed,
    output logic [WT_W-1:0]  weight_packed,
    input  logic [OUT_W-1:0] mac_out,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(L_MAX);
    localparam logic [CNT_W-1:0] LEN_IN   = CNT_W'(IN_W);

    loader_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic             keep_lat;

    logic             accept;
    logic             keep_now;
    logic [CNT_W-1:0] len_now;
    logic             lane_en;
    logic             w_en;
    logic             last_bit;
    logic [IN_W-1:0]  in_next;
    logic [WT_W-1:0]  w_next;

    // keep_weight only counts on the accepting edge; afterwards the latched copy rules.
    assign accept   = (state == IDLE) && start;
    assign keep_now = accept ? keep_weight : keep_lat;
    assign len_now  = keep_now ? LEN_IN : LEN_FULL;
    assign lane_en  = accept || (state == LOAD);
    assign w_en     = lane_en && !keep_now;
    assign last_bit = (accept && (len_now == CNT_W'(1)))
                   || ((state == LOAD) && (cnt == len_now - CNT_W'(1)));
    assign dbg_state = state;

    serial_shift_lane #(.WIDTH(IN_W)) u_in_lane (
        .CLK      (CLK),
        .reset    (reset),
        .first    (accept),
        .en       (lane_en),
        .bit_in   (ser_in),
        .par_next (in_next)
    );

    serial_shift_lane #(.WIDTH(WT_W)) u_w_lane (
        .CLK      (CLK),
        .reset    (reset),
        .first    (accept),
        .en       (w_en),
        .bit_in   (ser_w),
        .par_next (w_next)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            keep_lat      <= 1'b0;
            in_packed     <= '0;
            weight_packed <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        keep_lat <= keep_weight;
                        cnt      <= CNT_W'(1);
                        busy     <= 1'b1;
                        if (last_bit) begin
                            in_packed <= in_next;
                            if (!keep_now) weight_packed <= w_next;
                            state <= WAIT;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt <= cnt + CNT_W'(1);
                    // Packed outputs move only here, so the MAC never sees a partial vector.
                    if (last_bit) begin
                        in_packed <= in_next;
                        if (!keep_now) weight_packed <= w_next;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state <= CAPT;
                end
                CAPT: begin
                    result       <= mac_out;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: attaches a registered popcount MAC, drives serial loads,
// and checks every cycle against a load-level model plus a result scoreboard.
module tb_mac_operand_loader;
    import mac_pkg::*;

    localparam int L_TB = 32;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             keep_weight = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_w = 1'b0;
    logic [IN_W-1:0]  in_packed;
    logic [WT_W-1:0]  weight_packed;
    logic [OUT_W-1:0] mac_out = '0;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [31:0]      cur_w = '0;

    // model state
    int          m_t = 0;
    bit          m_active = 1'b0;
    bit          m_keep = 1'b0;
    logic [31:0] m_ib = '0;
    logic [31:0] m_wb = '0;
    logic [31:0] m_in = '0;
    logic [31:0] m_w = '0;
    int          m_pending = 0;
    logic [OUT_W-1:0] m_res = '0;
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          busy_len = 0;

    mac_operand_loader dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .keep_weight   (keep_weight),
        .ser_in        (ser_in),
        .ser_w         (ser_w),
        .in_packed     (in_packed),
        .weight_packed (weight_packed),
        .mac_out       (mac_out),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    function automatic int popc(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    // Binary MAC array stand-in: one register stage, synchronous reset.
    always @(posedge CLK) begin
        if (reset) mac_out <= '0;
        else       mac_out <= OUT_W'(popc(in_packed & weight_packed));
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Load-level model: counts edges since the accepted start.
    initial begin
        forever begin
            @(posedge CLK or posedge reset);
            if (reset) begin
                m_active = 0; m_t = 0; m_in = '0; m_w = '0; m_res = '0;
                m_valid = 0; m_busy = 0; m_pending = 0;
            end else begin
                m_valid = 0;
                if (m_active) begin
                    m_t++;
                    if (m_t < L_TB) begin
                        m_ib[m_t] = ser_in;
                        m_wb[m_t] = ser_w;
                    end
                    if (m_t == L_TB - 1) begin
                        m_in = m_ib;
                        if (!m_keep) m_w = m_wb;
                        m_pending = popc(m_in & m_w);
                    end
                    if (m_t == L_TB + 1) begin
                        m_res = OUT_W'(m_pending);
                        m_valid = 1;
                        m_active = 0;
                    end
                end else if (start) begin
                    m_active = 1; m_t = 0; m_keep = keep_weight;
                    m_ib[0] = ser_in; m_wb[0] = ser_w;
                end
                m_busy = m_active;
            end
        end
    end

    // Per-cycle compare, busy-length and result scoreboard.
    always @(negedge CLK) begin
        check("in_packed", 64'(in_packed), 64'(m_in));
        check("weight_packed", 64'(weight_packed), 64'(m_w));
        check("result", 64'(result), 64'(m_res));
        check("result_valid", 64'(result_valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_busy));
        if (reset) begin
            busy_len = 0;
        end else if (busy) begin
            busy_len++;
        end else if (busy_len > 0) begin
            check("busy_len", 64'(busy_len), 64'(L_TB + 1));
            busy_len = 0;
        end
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got result %0d expected no result_valid", result);
            end else begin
                check("sb_result", 64'(result), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in"}, 64'(in_packed), 64'd0);
        check({tag, "_w"}, 64'(weight_packed), 64'd0);
        check({tag, "_res"}, 64'(result), 64'd0);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // driver: bits are driven 2 time units after each rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #2;
            start = 1'b0;
            keep_weight = 1'($urandom_range(0, 1));
            ser_in = 1'($urandom_range(0, 1));
            ser_w = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_load(input bit k, input logic [31:0] ip, input logic [31:0] wp,
                           input int pulse_a, input int pulse_b, input int abort_at);
        logic [31:0] wv;
        @(posedge CLK); #2;
        start = 1'b1; keep_weight = k; ser_in = ip[0]; ser_w = wp[0];
        for (int i = 1; i < L_TB; i++) begin
            @(posedge CLK); #2;
            if (i == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                #1;
                check_all_zero("abort");
                repeat (3) @(posedge CLK);
                #2;
                reset = 1'b0;
                cur_w = '0;
                return;
            end
            start = (i == pulse_a) || (i == pulse_b);
            keep_weight = 1'($urandom_range(0, 1));
            ser_in = ip[i];
            ser_w = wp[i];
        end
        wv = k ? cur_w : wp;
        cur_w = wv;
        exp_q.push_back(OUT_W'(popc(ip & wv)));
    endtask

    initial begin
        logic [31:0] ip;
        logic [31:0] wp;
        bit k;

        repeat (3) @(posedge CLK);
        #2;
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // all ones on both lines
        do_load(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
        idle(4);
        check("lit_all1_in", 64'(in_packed), 64'hFFFF_FFFF);
        check("lit_all1_w", 64'(weight_packed), 64'hFFFF_FFFF);
        check("lit_all1_res", 64'(result), 64'd32);
        check("lit_all1_model", 64'(m_res), 64'd32);

        // alternating inputs, upper-half weights
        do_load(1'b0, 32'hAAAA_AAAA, 32'hFFFF_0000, -1, -1, -1);
        idle(4);
        check("lit_alt_in", 64'(in_packed), 64'hAAAA_AAAA);
        check("lit_alt_w", 64'(weight_packed), 64'hFFFF_0000);
        check("lit_alt_res", 64'(result), 64'd8);
        check("lit_alt_model_in", 64'(m_in), 64'hAAAA_AAAA);

        // weight reuse with noise on ser_w
        do_load(1'b1, 32'hFFFF_FFFF, $urandom, -1, -1, -1);
        idle(4);
        check("lit_keep_w", 64'(weight_packed), 64'hFFFF_0000);
        check("lit_keep_res", 64'(result), 64'd16);

        // stray starts mid-load, then a back-to-back zero-result run
        do_load(1'b0, $urandom, $urandom, 5, 20, -1);
        idle(2);
        do_load(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        idle(4);
        check("lit_zero_res", 64'(result), 64'd0);
        check("lit_zero_w", 64'(weight_packed), 64'hFFFF_FFFF);

        // abort at bit 10; held weights must be gone afterwards
        do_load(1'b0, $urandom, $urandom, -1, -1, 10);
        idle(2);
        do_load(1'b1, 32'hFFFF_FFFF, $urandom, -1, -1, -1);
        idle(4);
        check("lit_post_reset_w", 64'(weight_packed), 64'd0);
        check("lit_post_reset_res", 64'(result), 64'd0);
        check("lit_post_reset_in", 64'(in_packed), 64'hFFFF_FFFF);

        // random loads with random reuse and gaps (gap 2 = back-to-back)
        for (int r = 0; r < 8; r++) begin
            k = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ip = $urandom;
            wp = $urandom;
            do_load(k, ip, wp, $urandom_range(1, 40), -1, -1);
            idle($urandom_range(2, 5));
        end

        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge CLK);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
